// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin arbiter sharing one L2 request slot among NUM_REQS
// masters. Grants go through a 2-entry skid buffer, and the requester index is
// appended to the tag in its LSBs. Responses are steered back by that index.
module l2_req_arbiter #(
    parameter int  NUM_REQS      = 4,
    parameter int  ADDR_WIDTH    = 26,
    parameter int  DATA_SIZE     = 64,
    parameter int  TAG_WIDTH     = 8,
    localparam int SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
    localparam int TAG_OUT_WIDTH = TAG_WIDTH + SEL_BITS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid_in,
    input  logic [NUM_REQS-1:0]               req_rw_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_REQS*DATA_SIZE*8-1:0]   req_data_in,
    input  logic [NUM_REQS*DATA_SIZE-1:0]     req_byteen_in,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag_in,
    output logic [NUM_REQS-1:0]               req_ready_in,
    output logic                              req_valid_out,
    output logic                              req_rw_out,
    output logic [ADDR_WIDTH-1:0]             req_addr_out,
    output logic [DATA_SIZE*8-1:0]            req_data_out,
    output logic [DATA_SIZE-1:0]              req_byteen_out,
    output logic [TAG_OUT_WIDTH-1:0]          req_tag_out,
    input  logic                              req_ready_out,
    input  logic                              rsp_valid_in,
    input  logic [DATA_SIZE*8-1:0]            rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]          rsp_tag_in,
    output logic                              rsp_ready_in,
    output logic [NUM_REQS-1:0]               rsp_valid_out,
    output logic [NUM_REQS*DATA_SIZE*8-1:0]   rsp_data_out,
    output logic [NUM_REQS*TAG_WIDTH-1:0]     rsp_tag_out,
    input  logic [NUM_REQS-1:0]               rsp_ready_out
);
    localparam int SEL_W  = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int DATA_W = DATA_SIZE * 8;
    localparam int ENT_W  = 1 + ADDR_WIDTH + DATA_W + DATA_SIZE + TAG_OUT_WIDTH;

    logic [SEL_W-1:0]         ptr_q, ptr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [ENT_W-1:0]         ent0_q, ent0_d;   // head entry drives the outputs
    logic [ENT_W-1:0]         ent1_q, ent1_d;
    logic                     grant_found_s;
    logic [SEL_W-1:0]         grant_idx_s;
    logic [TAG_WIDTH-1:0]     tag_sel_s;
    logic [TAG_OUT_WIDTH-1:0] new_tag_s;
    logic [ENT_W-1:0]         new_ent_s;
    logic                     full_s, push_s, pop_s;
    logic [TAG_WIDTH-1:0]     rsp_tag_s;
    logic                     rsp_oob_s;

    // Full comes from the registered count only, so req_ready_out never reaches req_ready_in.
    assign full_s = (cnt_q == 2'd2);
    assign push_s = grant_found_s & ~full_s;
    assign pop_s  = (cnt_q != 2'd0) & req_ready_out;

    // Round-robin search starting at the pointer and wrapping past the top index.
    always_comb begin
        int cand;
        cand          = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end else begin
                cand = cand;
            end
            if (!grant_found_s && req_valid_in[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = SEL_W'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Only the granted requester sees ready, and only while the buffer has room.
    always_comb begin
        req_ready_in = '0;
        if (push_s) begin
            req_ready_in[grant_idx_s] = 1'b1;
        end else begin
            req_ready_in = '0;
        end
    end

    assign tag_sel_s = req_tag_in[grant_idx_s*TAG_WIDTH +: TAG_WIDTH];

    if (SEL_BITS > 0) begin : g_tag_idx
        assign new_tag_s = {tag_sel_s, grant_idx_s};
    end else begin : g_tag_pass
        assign new_tag_s = tag_sel_s;
    end

    assign new_ent_s = {req_rw_in[grant_idx_s],
                        req_addr_in[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH],
                        req_data_in[grant_idx_s*DATA_W +: DATA_W],
                        req_byteen_in[grant_idx_s*DATA_SIZE +: DATA_SIZE],
                        new_tag_s};

    // Pointer moves just past the winner on accept, else holds.
    always_comb begin
        ptr_d = ptr_q;
        if (push_s) begin
            if (grant_idx_s == SEL_W'(NUM_REQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + SEL_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Two-entry FIFO next state; a simultaneous push and pop keeps the count.
    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push_s, pop_s})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    ent0_d = new_ent_s;
                end else begin
                    ent1_d = new_ent_s;
                end
            end
            2'b01: begin
                cnt_d  = cnt_q - 2'd1;
                ent0_d = ent1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = new_ent_s;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent_s;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State registers; reset empties the buffer and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    assign req_valid_out  = (cnt_q != 2'd0);
    assign req_tag_out    = ent0_q[TAG_OUT_WIDTH-1:0];
    assign req_byteen_out = ent0_q[TAG_OUT_WIDTH +: DATA_SIZE];
    assign req_data_out   = ent0_q[TAG_OUT_WIDTH+DATA_SIZE +: DATA_W];
    assign req_addr_out   = ent0_q[TAG_OUT_WIDTH+DATA_SIZE+DATA_W +: ADDR_WIDTH];
    assign req_rw_out     = ent0_q[ENT_W-1];

    if (SEL_BITS > 0) begin : g_rsp_demux
        logic [SEL_BITS-1:0] rsp_idx_s;
        assign rsp_idx_s = rsp_tag_in[SEL_BITS-1:0];
        assign rsp_tag_s = rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];
        // Steer valid/ready by index; an index with no requester is consumed and dropped.
        always_comb begin
            rsp_valid_out = '0;
            rsp_ready_in  = 1'b1;
            rsp_oob_s     = 1'b1;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (rsp_idx_s == SEL_BITS'(i)) begin
                    rsp_valid_out[i] = rsp_valid_in;
                    rsp_ready_in     = rsp_ready_out[i];
                    rsp_oob_s        = 1'b0;
                end else begin
                    rsp_valid_out[i] = 1'b0;
                end
            end
        end
    end else begin : g_rsp_single
        assign rsp_tag_s     = rsp_tag_in;
        assign rsp_valid_out = rsp_valid_in;
        assign rsp_ready_in  = rsp_ready_out[0];
        assign rsp_oob_s     = 1'b0;
    end

    assign rsp_data_out = {NUM_REQS{rsp_data_in}};
    assign rsp_tag_out  = {NUM_REQS{rsp_tag_s}};

    l2_req_arbiter_chk #(
        .NUM_REQS   (NUM_REQS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_SIZE  (DATA_SIZE),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_chk (
        .clk           (clk),
        .reset         (reset),
        .req_valid_in  (req_valid_in),
        .req_ready_in  (req_ready_in),
        .req_rw_in     (req_rw_in),
        .req_addr_in   (req_addr_in),
        .req_data_in   (req_data_in),
        .req_byteen_in (req_byteen_in),
        .req_tag_in    (req_tag_in),
        .rsp_valid_in  (rsp_valid_in),
        .rsp_idx_oob   (rsp_oob_s)
    );
endmodule

// l2_req_arbiter_chk: protocol checks for requester stability and response index range.
module l2_req_arbiter_chk #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_SIZE  = 64,
    parameter int TAG_WIDTH  = 8
) (
    input logic                            clk,
    input logic                            reset,
    input logic [NUM_REQS-1:0]             req_valid_in,
    input logic [NUM_REQS-1:0]             req_ready_in,
    input logic [NUM_REQS-1:0]             req_rw_in,
    input logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr_in,
    input logic [NUM_REQS*DATA_SIZE*8-1:0] req_data_in,
    input logic [NUM_REQS*DATA_SIZE-1:0]   req_byteen_in,
    input logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag_in,
    input logic                            rsp_valid_in,
    input logic                            rsp_idx_oob
);
    localparam int DATA_W = DATA_SIZE * 8;

    logic [NUM_REQS-1:0]             hold_q;
    logic [NUM_REQS-1:0]             rw_q;
    logic [NUM_REQS*ADDR_WIDTH-1:0]  addr_q;
    logic [NUM_REQS*DATA_W-1:0]      data_q;
    logic [NUM_REQS*DATA_SIZE-1:0]   byteen_q;
    logic [NUM_REQS*TAG_WIDTH-1:0]   tag_q;

    // Remember which requesters were stalled and what they were presenting.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= req_valid_in & ~req_ready_in;
        end
        rw_q     <= req_rw_in;
        addr_q   <= req_addr_in;
        data_q   <= req_data_in;
        byteen_q <= req_byteen_in;
        tag_q    <= req_tag_in;
    end

    // A stalled requester that stays valid must present the same fields; responses must map to a requester.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!reset && hold_q[i] && req_valid_in[i]) begin
                assert (req_rw_in[i] == rw_q[i] &&
                        req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_q[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                        req_data_in[i*DATA_W +: DATA_W] == data_q[i*DATA_W +: DATA_W] &&
                        req_byteen_in[i*DATA_SIZE +: DATA_SIZE] == byteen_q[i*DATA_SIZE +: DATA_SIZE] &&
                        req_tag_in[i*TAG_WIDTH +: TAG_WIDTH] == tag_q[i*TAG_WIDTH +: TAG_WIDTH]);
            end
        end
        if (!reset && rsp_valid_in) begin
            assert (!rsp_idx_oob);
        end
    end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter with hand-computed expectations (NUM_REQS=4).
module tb_l2_req_arbiter;
    localparam int N   = 4;
    localparam int AW  = 26;
    localparam int DS  = 64;
    localparam int TW  = 8;
    localparam int TOW = 10;
    localparam int DW  = DS * 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid_in;
    logic [N-1:0]      req_rw_in;
    logic [N*AW-1:0]   req_addr_in;
    logic [N*DW-1:0]   req_data_in;
    logic [N*DS-1:0]   req_byteen_in;
    logic [N*TW-1:0]   req_tag_in;
    logic [N-1:0]      req_ready_in;
    logic              req_valid_out;
    logic              req_rw_out;
    logic [AW-1:0]     req_addr_out;
    logic [DW-1:0]     req_data_out;
    logic [DS-1:0]     req_byteen_out;
    logic [TOW-1:0]    req_tag_out;
    logic              req_ready_out;
    logic              rsp_valid_in;
    logic [DW-1:0]     rsp_data_in;
    logic [TOW-1:0]    rsp_tag_in;
    logic              rsp_ready_in;
    logic [N-1:0]      rsp_valid_out;
    logic [N*DW-1:0]   rsp_data_out;
    logic [N*TW-1:0]   rsp_tag_out;
    logic [N-1:0]      rsp_ready_out;

    int n_vec = 0;
    int n_err = 0;

    l2_req_arbiter #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
        .req_data_in(req_data_in), .req_byteen_in(req_byteen_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in), .req_valid_out(req_valid_out), .req_rw_out(req_rw_out),
        .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_byteen_out(req_byteen_out),
        .req_tag_out(req_tag_out), .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
        .rsp_ready_in(rsp_ready_in), .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
        .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
        req_addr_in[i*AW +: AW]   = a;
        req_tag_in[i*TW +: TW]    = t;
        req_data_in[i*DW +: DW]   = {16{32'hCAFE0000 + 32'(i)}};
        req_byteen_in[i*DS +: DS] = {DS{1'b1}};
        req_rw_in[i]              = (i % 2 == 1);
    endtask

    function automatic logic [31:0] etag(input int i);
        return 32'((32'h10 + 32'(i)) * 32'd4 + 32'(i));
    endfunction

    initial begin
        reset = 1'b1; req_valid_in = '0; req_rw_in = '0; req_addr_in = '0; req_data_in = '0;
        req_byteen_in = '0; req_tag_in = '0; req_ready_out = 1'b0; rsp_valid_in = 1'b0;
        rsp_data_in = '0; rsp_tag_in = '0; rsp_ready_out = '0;
        set_req(2, 26'h100, 8'h5A);
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_valid_out", 32'(req_valid_out), 32'd0);
        chk("rst_ready_in", 32'(req_ready_in), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);

        // Test 1: lone requester 2
        tick(); req_valid_in = 4'b0100; req_ready_out = 1'b1; #1;
        chk("t1_ready_in", 32'(req_ready_in), 32'h4);
        chk("t1_vout_pre", 32'(req_valid_out), 32'd0);
        tick(); req_valid_in = 4'b0000; #1;
        chk("t1_vout", 32'(req_valid_out), 32'd1);
        chk("t1_addr", 32'(req_addr_out), 32'h100);
        chk("t1_tag", 32'(req_tag_out), 32'h16A);
        tick(); #1;
        chk("t1_drained", 32'(req_valid_out), 32'd0);

        // Test 2: all valid, sink always ready
        for (int i = 0; i < N; i++) set_req(i, 26'(32'h200 + 32'(i)), 8'(32'h10 + 32'(i)));
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; req_valid_in = 4'b1111; req_ready_out = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            #1;
            chk("t2_grant", 32'(req_ready_in), 32'(1) << (k % 4));
            if (k > 0) begin
                chk("t2_vout", 32'(req_valid_out), 32'd1);
                chk("t2_addr", 32'(req_addr_out), 32'h200 + 32'((k - 1) % 4));
                chk("t2_tag", 32'(req_tag_out), etag((k - 1) % 4));
            end
        end

        // Test 3: sink stalled, buffer fills with req0/req1
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; req_valid_in = 4'b1111; req_ready_out = 1'b0; #1;
        chk("t3_g0", 32'(req_ready_in), 32'h1);
        tick(); #1;
        chk("t3_g1", 32'(req_ready_in), 32'h2);
        chk("t3_vout", 32'(req_valid_out), 32'd1);
        chk("t3_addr0", 32'(req_addr_out), 32'h200);
        tick(); #1;
        chk("t3_full", 32'(req_ready_in), 32'h0);
        chk("t3_tag0", 32'(req_tag_out), etag(0));
        tick(); #1;
        chk("t3_stable", 32'(req_addr_out), 32'h200);
        tick(); req_ready_out = 1'b1; #1;
        chk("t3_full_rel", 32'(req_ready_in), 32'h0);
        chk("t3_head0", 32'(req_addr_out), 32'h200);
        tick(); #1;
        chk("t3_g2", 32'(req_ready_in), 32'h4);
        chk("t3_head1", 32'(req_addr_out), 32'h201);
        tick(); #1;
        chk("t3_g3", 32'(req_ready_in), 32'h8);
        chk("t3_head2", 32'(req_addr_out), 32'h202);
        tick(); req_valid_in = 4'b0000; #1;
        chk("t3_head3", 32'(req_addr_out), 32'h203);
        tick(); #1;
        chk("t3_empty", 32'(req_valid_out), 32'd0);

        // Test 4: pointer wrapped to 0 after req3
        tick(); req_valid_in = 4'b1010; #1;
        chk("t4_g1", 32'(req_ready_in), 32'h2);
        tick(); #1;
        chk("t4_g3", 32'(req_ready_in), 32'h8);
        tick(); #1;
        chk("t4_g1b", 32'(req_ready_in), 32'h2);
        tick(); req_valid_in = 4'b0000;

        // Test 5: response demux
        tick();
        rsp_valid_in = 1'b1; rsp_tag_in = 10'h16A; rsp_ready_out = 4'b1011;
        rsp_data_in = {16{32'h600DF00D}}; #1;
        chk("t5_rvalid", 32'(rsp_valid_out), 32'h4);
        chk("t5_rready0", 32'(rsp_ready_in), 32'd0);
        rsp_ready_out = 4'b1111; #1;
        chk("t5_rready1", 32'(rsp_ready_in), 32'd1);
        chk("t5_tag2", 32'(rsp_tag_out[2*TW +: TW]), 32'h5A);
        chk("t5_tag0", 32'(rsp_tag_out[0 +: TW]), 32'h5A);
        chk("t5_data2", rsp_data_out[2*DW +: 32], 32'h600DF00D);
        rsp_tag_in = 10'h0C7; rsp_ready_out = 4'b0111; #1;
        chk("t5_rvalid3", 32'(rsp_valid_out), 32'h8);
        chk("t5_rready3", 32'(rsp_ready_in), 32'd0);
        rsp_valid_in = 1'b0; #1;
        chk("t5_idle", 32'(rsp_valid_out), 32'd0);

        // Test 6: reset with two entries buffered
        tick(); req_valid_in = 4'b0011; req_ready_out = 1'b0; #1;
        chk("t6_g0", 32'(req_ready_in), 32'h1);
        tick(); #1;
        chk("t6_g1", 32'(req_ready_in), 32'h2);
        tick(); #1;
        chk("t6_full", 32'(req_ready_in), 32'h0);
        chk("t6_vout", 32'(req_valid_out), 32'd1);
        chk("t6_addr", 32'(req_addr_out), 32'h200);
        reset = 1'b1;
        tick(); reset = 1'b0; req_valid_in = 4'b0101; #1;
        chk("t6_rst_vout", 32'(req_valid_out), 32'd0);
        chk("t6_rst_grant", 32'(req_ready_in), 32'h1);
        tick(); req_valid_in = 4'b0000; req_ready_out = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
